// File: rtl/simple_dma_write_controller_pkg.sv
// Shared widths, register map, command encodings and bus payload types for the DMA write controller.
package simple_dma_write_controller_pkg;

  // FSAB bus widths
  localparam int unsigned FSAB_REQ_W  = 1;
  localparam int unsigned FSAB_DID_W  = 4;
  localparam int unsigned FSAB_ADDR_W = 31;
  localparam int unsigned FSAB_LEN_W  = 4;
  localparam int unsigned FSAB_DATA_W = 64;
  localparam int unsigned FSAB_MASK_W = 8;

  localparam logic [FSAB_REQ_W-1:0] FSAB_WRITE = 1'b1;
  localparam int unsigned FSAB_INITIAL_CREDITS = 8;
  localparam int unsigned CREDIT_W = 8;

  // Burst geometry: 8 beats of 8 bytes
  localparam int unsigned BURST_BEATS = 8;
  localparam int unsigned BURST_BYTES = 64;
  localparam int unsigned BEAT_W      = 3;
  localparam logic [FSAB_LEN_W-1:0] FSAB_BURST_LEN = 4'd8;

  // SPAM bus widths
  localparam int unsigned SPAM_DID_W  = 4;
  localparam int unsigned SPAM_ADDR_W = 24;
  localparam int unsigned SPAM_DATA_W = 32;

  // Register map (offsets after the prefix mask is removed)
  localparam logic [SPAM_ADDR_W-1:0] NEXT_START_REG_ADDR = 24'h000000;
  localparam logic [SPAM_ADDR_W-1:0] NEXT_LEN_REG_ADDR   = 24'h000004;
  localparam logic [SPAM_ADDR_W-1:0] COMMAND_REG_ADDR    = 24'h000008;

  // Command encodings
  localparam int unsigned COMMAND_W = 2;
  localparam int unsigned COMMAND_REGISTER_HI = COMMAND_W - 1;
  localparam logic [COMMAND_W-1:0] DMA_STOP         = 2'd0;
  localparam logic [COMMAND_W-1:0] DMA_TRIGGER_ONCE = 2'd1;
  localparam logic [COMMAND_W-1:0] DMA_AUTOTRIGGER  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  typedef struct packed {
    logic [FSAB_REQ_W-1:0]  mode;
    logic [FSAB_DID_W-1:0]  did;
    logic [FSAB_DID_W-1:0]  subdid;
    logic [FSAB_ADDR_W-1:0] addr;
    logic [FSAB_LEN_W-1:0]  len;
    logic [FSAB_DATA_W-1:0] data;
    logic [FSAB_MASK_W-1:0] mask;
  } fsab_req_t;

  // True when a SPAM request targets this block (device ID and masked prefix both match)
  function automatic logic spam_match(
    input logic [SPAM_DID_W-1:0]  req_did,
    input logic [SPAM_ADDR_W-1:0] req_addr,
    input logic [SPAM_DID_W-1:0]  my_did,
    input logic [SPAM_ADDR_W-1:0] pfx,
    input logic [SPAM_ADDR_W-1:0] mask
  );
    return (req_did == my_did) && ((req_addr & mask) == pfx);
  endfunction

endpackage

// File: rtl/simple_dma_write_controller_if.sv
// Bundles the FSAB request path, SPAM register port and producer push port of the DMA write controller.
interface simple_dma_write_controller_if;
  import simple_dma_write_controller_pkg::*;

  logic                   dmac__fsabo_valid;
  logic [FSAB_REQ_W-1:0]  dmac__fsabo_mode;
  logic [FSAB_DID_W-1:0]  dmac__fsabo_did;
  logic [FSAB_DID_W-1:0]  dmac__fsabo_subdid;
  logic [FSAB_ADDR_W-1:0] dmac__fsabo_addr;
  logic [FSAB_LEN_W-1:0]  dmac__fsabo_len;
  logic [FSAB_DATA_W-1:0] dmac__fsabo_data;
  logic [FSAB_MASK_W-1:0] dmac__fsabo_mask;
  logic                   dmac__fsabo_credit;

  logic                   spamo_valid;
  logic                   spamo_r_nw;
  logic [SPAM_DID_W-1:0]  spamo_did;
  logic [SPAM_ADDR_W-1:0] spamo_addr;
  logic [SPAM_DATA_W-1:0] spamo_data;
  logic                   dmac__spami_busy_b;
  logic [SPAM_DATA_W-1:0] dmac__spami_data;

  logic [FSAB_DATA_W-1:0] data;
  logic                   data_valid;
  logic                   data_ready;

  modport master (
    output dmac__fsabo_valid, dmac__fsabo_mode, dmac__fsabo_did, dmac__fsabo_subdid,
    output dmac__fsabo_addr, dmac__fsabo_len, dmac__fsabo_data, dmac__fsabo_mask,
    input  dmac__fsabo_credit,
    input  spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data,
    output dmac__spami_busy_b, dmac__spami_data,
    input  data, data_valid,
    output data_ready
  );

  modport slave (
    input  dmac__fsabo_valid, dmac__fsabo_mode, dmac__fsabo_did, dmac__fsabo_subdid,
    input  dmac__fsabo_addr, dmac__fsabo_len, dmac__fsabo_data, dmac__fsabo_mask,
    output dmac__fsabo_credit,
    output spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data,
    input  dmac__spami_busy_b, dmac__spami_data,
    output data, data_valid,
    input  data_ready
  );
endinterface

// File: rtl/simple_dma_write_controller_fifo.sv
// Show-ahead synchronous FIFO holding producer words until the burst engine drains them.
module dma_sync_fifo #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_c_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ready_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  // Pointer/count update; ready is precomputed so it is a flop output
  always_comb begin
    do_push  = push_i && ready_q;
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ready_d  = (count_d < CW'(DEPTH));
  end

  // Control state; reset flushes the FIFO
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign ready_o  = ready_q;
endmodule

// File: rtl/simple_dma_write_controller.sv
// DMA engine streaming producer words into memory as 64-byte FSAB write bursts, programmed over SPAM.
module simple_dma_write_controller
  import simple_dma_write_controller_pkg::*;
#(
  parameter int unsigned            FIFO_DEPTH    = 128,
  parameter logic [FSAB_DID_W-1:0]  FSAB_DID      = 4'hF,
  parameter logic [FSAB_DID_W-1:0]  FSAB_SUBDID   = 4'hF,
  parameter logic [SPAM_DID_W-1:0]  SPAM_DID      = 4'h0,
  parameter logic [SPAM_ADDR_W-1:0] SPAM_ADDRPFX  = 24'h000000,
  parameter logic [SPAM_ADDR_W-1:0] SPAM_ADDRMASK = 24'h000000,
  parameter logic [FSAB_ADDR_W-1:0] DEFAULT_ADDR  = 31'h0,
  parameter logic [FSAB_ADDR_W-1:0] DEFAULT_LEN   = 31'h0
) (
  input logic                         clk,
  input logic                         rst_b,
  simple_dma_write_controller_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [FSAB_ADDR_W-1:0] addr_q, addr_d;
  logic [FSAB_ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [FSAB_ADDR_W-1:0] next_start_q, next_start_d;
  logic [FSAB_ADDR_W-1:0] next_len_q, next_len_d;
  logic [COMMAND_W-1:0]   cmd_q, cmd_d;
  logic [CREDIT_W-1:0]    credits_q, credits_d;
  fsab_req_t              req_q, req_d;
  logic                   valid_q, valid_d;
  logic                   busy_b_q, busy_b_d;
  logic [SPAM_DATA_W-1:0] rdata_q, rdata_d;

  logic                   pop, fire, triggered;
  logic                   spam_hit;
  logic [SPAM_ADDR_W-1:0] reg_off;
  logic [CNT_W-1:0]       fifo_count;
  logic [FSAB_DATA_W-1:0] fifo_head;
  logic                   fifo_ready;
  logic                   unused_spam_msb;

  dma_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FSAB_DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_b       (rst_b),
    .push_i      (bus.data_valid),
    .push_data_i (bus.data),
    .pop_i       (pop),
    .head_c_o    (fifo_head),
    .count_o     (fifo_count),
    .ready_o     (fifo_ready)
  );

  assign triggered       = (state_q != ST_IDLE);
  assign unused_spam_msb = ^bus.spamo_data[SPAM_DATA_W-1:FSAB_ADDR_W];

  // Burst FSM: trigger latch, arm on data+credits, 8 gapless beats, then rearm or finish
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    end_addr_d = end_addr_q;
    pop        = 1'b0;
    fire       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_q == DMA_TRIGGER_ONCE || cmd_q == DMA_AUTOTRIGGER) begin
          fire       = 1'b1;
          addr_d     = next_start_q;
          end_addr_d = next_start_q + next_len_q;
          if (next_len_q != '0) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (fifo_count >= CNT_W'(BURST_BEATS) && credits_q >= CREDIT_W'(BURST_BEATS)) begin
          state_d = ST_BURST;
          beat_d  = '0;
          pop     = 1'b1;
        end
      end
      ST_BURST: begin
        if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
          if (addr_q + FSAB_ADDR_W'(BURST_BYTES) == end_addr_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + FSAB_ADDR_W'(BURST_BYTES);
            state_d = ST_ARMED;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          pop    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_BURST);
    req_d   = '0;
    if (valid_d) begin
      req_d.mode   = FSAB_WRITE;
      req_d.did    = FSAB_DID;
      req_d.subdid = FSAB_SUBDID;
      req_d.addr   = addr_q;
      req_d.len    = FSAB_BURST_LEN;
      req_d.data   = fifo_head;
      req_d.mask   = '1;
    end
  end

  // SPAM register file and credit accounting
  always_comb begin
    spam_hit     = bus.spamo_valid &&
                   spam_match(bus.spamo_did, bus.spamo_addr, SPAM_DID, SPAM_ADDRPFX, SPAM_ADDRMASK);
    reg_off      = bus.spamo_addr & ~SPAM_ADDRMASK;
    next_start_d = next_start_q;
    next_len_d   = next_len_q;
    cmd_d        = cmd_q;
    busy_b_d     = spam_hit;
    rdata_d      = '0;
    if (fire && cmd_q == DMA_TRIGGER_ONCE) cmd_d = DMA_STOP;
    if (spam_hit && !bus.spamo_r_nw) begin
      if (reg_off == NEXT_START_REG_ADDR) next_start_d = bus.spamo_data[FSAB_ADDR_W-1:0];
      if (reg_off == NEXT_LEN_REG_ADDR)   next_len_d   = bus.spamo_data[FSAB_ADDR_W-1:0];
      if (reg_off == COMMAND_REG_ADDR)    cmd_d        = bus.spamo_data[COMMAND_REGISTER_HI:0];
    end
    if (spam_hit && bus.spamo_r_nw && reg_off == COMMAND_REG_ADDR) begin
      rdata_d = SPAM_DATA_W'({fifo_count, triggered});
    end
    credits_d = credits_q + CREDIT_W'(bus.dmac__fsabo_credit) - CREDIT_W'(valid_q);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      addr_q       <= '0;
      end_addr_q   <= '0;
      next_start_q <= DEFAULT_ADDR;
      next_len_q   <= DEFAULT_LEN;
      cmd_q        <= DMA_STOP;
      credits_q    <= CREDIT_W'(FSAB_INITIAL_CREDITS);
      req_q        <= '0;
      valid_q      <= 1'b0;
      busy_b_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      end_addr_q   <= end_addr_d;
      next_start_q <= next_start_d;
      next_len_q   <= next_len_d;
      cmd_q        <= cmd_d;
      credits_q    <= credits_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      busy_b_q     <= busy_b_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.dmac__fsabo_valid  = valid_q;
  assign bus.dmac__fsabo_mode   = req_q.mode;
  assign bus.dmac__fsabo_did    = req_q.did;
  assign bus.dmac__fsabo_subdid = req_q.subdid;
  assign bus.dmac__fsabo_addr   = req_q.addr;
  assign bus.dmac__fsabo_len    = req_q.len;
  assign bus.dmac__fsabo_data   = req_q.data;
  assign bus.dmac__fsabo_mask   = req_q.mask;
  assign bus.dmac__spami_busy_b = busy_b_q;
  assign bus.dmac__spami_data   = rdata_q;
  assign bus.data_ready         = fifo_ready;
endmodule
